// File: rtl/fpna_pkg.sv
// Shared FPNA constants and configuration-chain geometry helpers.
// The array builder and test code use these to locate neuron fields in the bitstream.
package fpna_pkg;

  localparam int N_DEND_DEF = 3;
  localparam int W_W_DEF    = 3;
  localparam int U_W_DEF    = 5;
  localparam int TSEL_W_DEF = 3;
  localparam int REFR_W_DEF = 2;

  // Each dendrite slot holds {inh, mag[W_W-1:0]}.
  function automatic int dend_off(input int i, input int w_w);
    return i * (w_w + 1);
  endfunction

  function automatic int tsel_off(input int n_dend, input int w_w);
    return n_dend * (w_w + 1);
  endfunction

  function automatic int refr_off(input int n_dend, input int w_w, input int tsel_w);
    return tsel_off(n_dend, w_w) + tsel_w;
  endfunction

  function automatic int thr_off(input int n_dend, input int w_w, input int tsel_w,
                                 input int refr_w);
    return refr_off(n_dend, w_w, tsel_w) + refr_w;
  endfunction

  function automatic int chain_len(input int n_dend, input int w_w, input int tsel_w,
                                   input int refr_w, input int u_w);
    return thr_off(n_dend, w_w, tsel_w, refr_w) + u_w;
  endfunction

endpackage

// File: rtl/lif_neuron_cfg_if.sv
// Neuron tile signal bundle: configuration chain, dendrite/decay inputs, spike and debug outputs.
interface lif_neuron_cfg_if
  import fpna_pkg::*;
#(
  parameter int N_DEND = N_DEND_DEF,
  parameter int TSEL_W = TSEL_W_DEF,
  parameter int U_W    = U_W_DEF
);
  logic                     conf_en;
  logic                     nn_clear;
  logic                     bs_in;
  logic                     bs_out;
  logic [N_DEND-1:0]        dend;
  logic [(2**TSEL_W)-1:0]   dbus;
  logic                     axon;
  logic [U_W-1:0]           u_mon;

  modport slave (
    input  conf_en, nn_clear, bs_in, dend, dbus,
    output bs_out, axon, u_mon
  );

  modport master (
    output conf_en, nn_clear, bs_in, dend, dbus,
    input  bs_out, axon, u_mon
  );
endinterface

// File: rtl/neuron_cfg_chain.sv
// Serial configuration shift register; slices the stored word into neuron fields.
module neuron_cfg_chain
  import fpna_pkg::*;
#(
  parameter int N_DEND = N_DEND_DEF,
  parameter int W_W    = W_W_DEF,
  parameter int TSEL_W = TSEL_W_DEF,
  parameter int REFR_W = REFR_W_DEF,
  parameter int U_W    = U_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          shift_en_i,
  input  logic                          bs_i,
  output logic                          bs_o,
  output logic [N_DEND-1:0][W_W-1:0]    mag_o,
  output logic [N_DEND-1:0]             inh_o,
  output logic [TSEL_W-1:0]             tsel_o,
  output logic [REFR_W-1:0]             refr_o,
  output logic [U_W-1:0]                thresh_o
);
  localparam int L    = chain_len(N_DEND, W_W, TSEL_W, REFR_W, U_W);
  localparam int TOFF = tsel_off(N_DEND, W_W);
  localparam int ROFF = refr_off(N_DEND, W_W, TSEL_W);
  localparam int HOFF = thr_off(N_DEND, W_W, TSEL_W, REFR_W);

  logic [L-1:0] cfg_q, cfg_d;

  // First bit shifted in travels to the MSB, so the word is loaded threshold-first.
  always_comb begin
    cfg_d = cfg_q;
    if (shift_en_i) cfg_d = {cfg_q[L-2:0], bs_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_q <= '0;
    else        cfg_q <= cfg_d;
  end

  for (genvar i = 0; i < N_DEND; i++) begin : g_dend
    assign mag_o[i] = cfg_q[dend_off(i, W_W) +: W_W];
    assign inh_o[i] = cfg_q[dend_off(i, W_W) + W_W];
  end

  assign tsel_o   = cfg_q[TOFF +: TSEL_W];
  assign refr_o   = cfg_q[ROFF +: REFR_W];
  assign thresh_o = cfg_q[HOFF +: U_W];
  assign bs_o     = cfg_q[L-1];
endmodule

// File: rtl/lif_neuron_cfg.sv
// Configurable leaky integrate-and-fire neuron: signed dendrite weights, selectable leak,
// programmable threshold, refractory hold-off and saturating membrane potential.
module lif_neuron_cfg
  import fpna_pkg::*;
#(
  parameter int N_DEND = N_DEND_DEF,
  parameter int W_W    = W_W_DEF,
  parameter int U_W    = U_W_DEF,
  parameter int TSEL_W = TSEL_W_DEF,
  parameter int REFR_W = REFR_W_DEF
) (
  input  logic             clk,
  input  logic             nn_reset_n,
  lif_neuron_cfg_if.slave  nif
);
  localparam int SUM_W = U_W + $clog2(N_DEND) + 2;

  logic [N_DEND-1:0][W_W-1:0] mag;
  logic [N_DEND-1:0]          inh;
  logic [TSEL_W-1:0]          tsel;
  logic [REFR_W-1:0]          refr;
  logic [U_W-1:0]             thresh;
  logic                       bs_out_w;

  neuron_cfg_chain #(
    .N_DEND(N_DEND), .W_W(W_W), .TSEL_W(TSEL_W), .REFR_W(REFR_W), .U_W(U_W)
  ) u_chain (
    .clk        (clk),
    .rst_n      (nn_reset_n),
    .shift_en_i (nif.conf_en),
    .bs_i       (nif.bs_in),
    .bs_o       (bs_out_w),
    .mag_o      (mag),
    .inh_o      (inh),
    .tsel_o     (tsel),
    .refr_o     (refr),
    .thresh_o   (thresh)
  );

  logic [U_W-1:0]          u_q, u_d;
  logic [REFR_W-1:0]       rcnt_q, rcnt_d;
  logic                    axon_q, axon_d;

  logic [U_W-1:0]          ul;
  logic signed [SUM_W-1:0] sum_s;
  logic [U_W-1:0]          s_clamp;
  logic                    fire;

  // Sum is wide enough that leaked U plus every weight never wraps before the clamp.
  always_comb begin
    ul    = nif.dbus[tsel] ? (u_q >> 1) : u_q;
    sum_s = $signed({{(SUM_W-U_W){1'b0}}, ul});
    for (int i = 0; i < N_DEND; i++) begin
      if (nif.dend[i]) begin
        if (inh[i]) sum_s = sum_s - $signed({{(SUM_W-W_W){1'b0}}, mag[i]});
        else        sum_s = sum_s + $signed({{(SUM_W-W_W){1'b0}}, mag[i]});
      end
    end
    if (sum_s[SUM_W-1])              s_clamp = '0;
    else if (|sum_s[SUM_W-2:U_W])    s_clamp = '1;
    else                             s_clamp = sum_s[U_W-1:0];
    fire = (thresh != '0) && (s_clamp >= thresh);
  end

  // Configuration freezes the neuron; only the spike output is squashed.
  always_comb begin
    u_d    = u_q;
    rcnt_d = rcnt_q;
    axon_d = 1'b0;
    if (nif.conf_en) begin
      u_d    = u_q;
    end else if (nif.nn_clear) begin
      u_d    = '0;
      rcnt_d = '0;
    end else if (rcnt_q != '0) begin
      rcnt_d = rcnt_q - REFR_W'(1);
      u_d    = '0;
    end else if (fire) begin
      axon_d = 1'b1;
      u_d    = '0;
      rcnt_d = refr;
    end else begin
      u_d    = s_clamp;
    end
  end

  always_ff @(posedge clk or negedge nn_reset_n) begin
    if (!nn_reset_n) begin
      u_q    <= '0;
      rcnt_q <= '0;
      axon_q <= 1'b0;
    end else begin
      u_q    <= u_d;
      rcnt_q <= rcnt_d;
      axon_q <= axon_d;
    end
  end

  assign nif.axon   = axon_q;
  assign nif.u_mon  = u_q;
  assign nif.bs_out = bs_out_w;
endmodule

// File: tb/tb_lif_neuron_cfg.sv
// Scoreboard bench for lif_neuron_cfg: directed scenarios plus randomized traffic,
// all expectations produced by an integer-level neuron model.
module tb_lif_neuron_cfg;
  import fpna_pkg::*;

  localparam int N    = N_DEND_DEF;
  localparam int W    = W_W_DEF;
  localparam int U    = U_W_DEF;
  localparam int T    = TSEL_W_DEF;
  localparam int R    = REFR_W_DEF;
  localparam int DB   = 2**T;
  localparam int L    = chain_len(N, W, T, R, U);
  localparam int UMAX = (1 << U) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lif_neuron_cfg_if #(.N_DEND(N), .TSEL_W(T), .U_W(U)) nif ();

  lif_neuron_cfg #(.N_DEND(N), .W_W(W), .U_W(U), .TSEL_W(T), .REFR_W(R)) dut (
    .clk        (clk),
    .nn_reset_n (rst_n),
    .nif        (nif)
  );

  typedef struct {
    int    ax;
    int    u;
    int    bs;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state
  logic [L-1:0] m_cfg;
  int           m_u, m_r, m_ax;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int field(input int off, input int w);
    return int'((m_cfg >> off) & ((1 << w) - 1));
  endfunction

  function automatic logic [L-1:0] mk_cfg(input logic [N-1:0][W-1:0] mags,
                                          input logic [N-1:0] inhs, input int tsel,
                                          input int refr, input int th);
    logic [L-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      v[dend_off(i, W) +: W] = mags[i];
      v[dend_off(i, W) + W]  = inhs[i];
    end
    v[tsel_off(N, W) +: T]       = T'(tsel);
    v[refr_off(N, W, T) +: R]    = R'(refr);
    v[thr_off(N, W, T, R) +: U]  = U'(th);
    return v;
  endfunction

  // One clock of stimulus; the model decides what the edge should produce.
  task automatic drive_step(input bit ce, input bit clr, input bit bsi,
                            input logic [N-1:0] d, input logic [DB-1:0] db,
                            input string tag);
    exp_t e;
    int   ul, s, tsel, th, mg;
    @(negedge clk);
    nif.conf_en  = ce;
    nif.nn_clear = clr;
    nif.bs_in    = bsi;
    nif.dend     = d;
    nif.dbus     = db;
    if (ce) begin
      m_cfg = {m_cfg[L-2:0], bsi};
      m_ax  = 0;
    end else if (clr) begin
      m_u = 0; m_r = 0; m_ax = 0;
    end else if (m_r != 0) begin
      m_r  = m_r - 1;
      m_u  = 0;
      m_ax = 0;
    end else begin
      tsel = field(tsel_off(N, W), T);
      th   = field(thr_off(N, W, T, R), U);
      ul   = db[tsel] ? m_u / 2 : m_u;
      s    = ul;
      for (int i = 0; i < N; i++) begin
        if (d[i]) begin
          mg = field(dend_off(i, W), W);
          if (m_cfg[dend_off(i, W) + W]) s = s - mg;
          else                           s = s + mg;
        end
      end
      if (s < 0)    s = 0;
      if (s > UMAX) s = UMAX;
      if (th != 0 && s >= th) begin
        m_ax = 1; m_u = 0; m_r = field(refr_off(N, W, T), R);
      end else begin
        m_ax = 0; m_u = s;
      end
    end
    e.ax = m_ax; e.u = m_u; e.bs = int'(m_cfg[L-1]); e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic run(input logic [N-1:0] d, input logic [DB-1:0] db, input string tag);
    drive_step(1'b0, 1'b0, 1'b0, d, db, tag);
  endtask

  task automatic shift_cfg(input logic [L-1:0] v, input string tag);
    for (int k = L - 1; k >= 0; k--) drive_step(1'b1, 1'b0, v[k], '0, '0, tag);
  endtask

  task automatic clear(input string tag);
    drive_step(1'b0, 1'b1, 1'b0, '0, '0, tag);
  endtask

  // Reset lands between edges and must take effect without a clock.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_bs_out"}, int'(nif.bs_out), 0);
    check({tag, "_u_mon"},  int'(nif.u_mon),  0);
    check({tag, "_axon"},   int'(nif.axon),   0);
    m_cfg = '0; m_u = 0; m_r = 0; m_ax = 0;
    nif.conf_en = 1'b0; nif.nn_clear = 1'b1; nif.dend = '0; nif.dbus = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every edge produces an observable state; compare it against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, "_axon"},   int'(nif.axon),   e.ax);
        check({e.tag, "_u_mon"},  int'(nif.u_mon),  e.u);
        check({e.tag, "_bs_out"}, int'(nif.bs_out), e.bs);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [L-1:0] pat, v;
    rst_n = 1'b0;
    nif.conf_en = 1'b0; nif.nn_clear = 1'b0; nif.bs_in = 1'b0;
    nif.dend = '0; nif.dbus = '0;
    m_cfg = '0; m_u = 0; m_r = 0; m_ax = 0;
    #3;
    check("reset_bs_out", int'(nif.bs_out), 0);
    check("reset_u_mon",  int'(nif.u_mon),  0);
    check("reset_axon",   int'(nif.axon),   0);
    @(negedge clk);
    rst_n = 1'b1;

    // Chain integrity and field decode
    pat = L'(22'h2A5C3);
    shift_cfg(pat, "chain_in");
    @(posedge clk); #2;
    for (int i = 0; i < N; i++) begin
      check("field_mag", int'(dut.u_chain.mag_o[i]), field(dend_off(i, W), W));
      check("field_inh", int'(dut.u_chain.inh_o[i]), int'(pat[dend_off(i, W) + W]));
    end
    check("field_tsel",   int'(dut.u_chain.tsel_o),   field(tsel_off(N, W), T));
    check("field_refr",   int'(dut.u_chain.refr_o),   field(refr_off(N, W, T), R));
    check("field_thresh", int'(dut.u_chain.thresh_o), field(thr_off(N, W, T, R), U));
    shift_cfg('0, "chain_out");

    // Integrate, fire, refractory
    shift_cfg(mk_cfg({3'd0, 3'd0, 3'd5}, 3'b000, 0, 2, 16), "cfg_int");
    clear("clr_int");
    for (int k = 0; k < 7; k++) run(3'b001, '0, "integrate");

    // Inhibition floors at zero
    shift_cfg(mk_cfg({3'd0, 3'd3, 3'd5}, 3'b010, 0, 0, 31), "cfg_inh");
    clear("clr_inh");
    run(3'b001, '0, "inh_pre"); run(3'b001, '0, "inh_pre");
    for (int k = 0; k < 5; k++) run(3'b010, '0, "inhibit");

    // Leak on the selected decay line only
    shift_cfg(mk_cfg({3'd0, 3'd0, 3'd6}, 3'b000, 2, 0, 0), "cfg_leak");
    clear("clr_leak");
    run(3'b001, '0, "leak_pre"); run(3'b001, '0, "leak_pre");
    for (int k = 0; k < 4; k++) run(3'b000, 8'h04, "leak");
    run(3'b001, '0, "leak_pre"); run(3'b001, '0, "leak_pre");
    for (int k = 0; k < 3; k++) run(3'b000, 8'h00, "hold");
    run(3'b000, 8'hFB, "hold_other_lines");

    // Saturation with firing disabled, then enable at the rail
    shift_cfg(mk_cfg({3'd7, 3'd7, 3'd7}, 3'b000, 0, 0, 0), "cfg_sat");
    clear("clr_sat");
    for (int k = 0; k < 3; k++) run(3'b111, '0, "saturate");
    shift_cfg(mk_cfg({3'd7, 3'd7, 3'd7}, 3'b000, 0, 0, 31), "cfg_sat_th");
    run(3'b111, '0, "fire_at_max");
    run(3'b111, '0, "after_fire");

    // Async reset mid-shift and mid-integration
    shift_cfg({L{1'b1}}, "cfg_ones");
    for (int k = 0; k < 5; k++) drive_step(1'b1, 1'b0, 1'b1, '0, '0, "mid_shift");
    async_reset("rst_shift");
    shift_cfg('0, "post_rst_cfg");
    shift_cfg(mk_cfg({3'd0, 3'd0, 3'd5}, 3'b000, 0, 0, 0), "cfg_rst_u");
    for (int k = 0; k < 3; k++) run(3'b001, '0, "pre_rst_u");
    async_reset("rst_integrate");
    shift_cfg(mk_cfg({3'd0, 3'd0, 3'd5}, 3'b000, 0, 0, 5), "cfg_rst_ax");
    run(3'b001, '0, "pre_rst_axon");
    async_reset("rst_axon");

    // Soft clear keeps configuration
    v = mk_cfg({3'd4, 3'd2, 3'd5}, 3'b010, 1, 1, 20);
    shift_cfg(v, "cfg_clr");
    for (int k = 0; k < 3; k++) run(3'b101, '0, "pre_clear");
    clear("soft_clear");
    for (int k = 0; k < L; k++)
      drive_step(1'b1, 1'b0, 1'($urandom_range(0, 1)), '0, '0, "clear_cfg_out");

    // Randomized traffic
    for (int r = 0; r < 6; r++) begin
      v = L'($urandom());
      shift_cfg(v, "rnd_cfg");
      clear("rnd_clr");
      for (int k = 0; k < 80; k++)
        drive_step(($urandom_range(0, 19) == 0), ($urandom_range(0, 31) == 0),
                   1'($urandom_range(0, 1)), N'($urandom()), DB'($urandom()), "random");
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lif_neuron_cfg.md
Name: lif_neuron_cfg

Overview:
- Parametrised leaky integrate-and-fire neuron tile for the FPNA array; successor to the fixed 3-dendrite, 3-bit-weight neuron.
- Adds:
  - N configurable dendrites, each with a per-dendrite excitatory/inhibitory sign bit.
  - Programmable firing threshold.
  - Refractory counter.
  - Saturating membrane arithmetic.
  - Decay applied on the single rising edge.
- Configured through the tile-wide serial bitstream chain (bs_in to bs_out).

Parameters:
- N_DEND, 3, number of dendritic inputs.
- W_W, 3, weight magnitude width.
- U_W, 5, membrane potential and threshold width.
- TSEL_W, 3, decay-bus selector width; decay bus is 2**TSEL_W lines.
- REFR_W, 2, refractory period width.

Ports:
- clk  in  1  tile clock.
- nn_reset_n  in  1  asynchronous active-low reset.
- conf_en  in  1  1 = shift the configuration chain; neuron frozen.
- nn_clear  in  1  synchronous soft clear of dynamic state; configuration kept.
- bs_in  in  1  serial configuration in.
- bs_out  out  1  serial configuration out = cfg[L-1].
- dend  in  N_DEND  dendritic spike inputs.
- dbus  in  2**TSEL_W  shared decay clock bus.
- axon  out  1  registered spike, one cycle wide.
- u_mon  out  U_W  membrane potential, for debug.

Behaviour:
- Chain length: L = N_DEND*(W_W+1) + TSEL_W + REFR_W + U_W.
- cfg[L-1:0] layout:
  - Dendrite i occupies cfg[i*(W_W+1) +: W_W+1]; bit W_W is inh, low bits are mag.
  - tsel at base D = N_DEND*(W_W+1).
  - refr at D+TSEL_W.
  - thresh at the top U_W bits.
- Chain shift:
  - On each clk with conf_en=1: cfg <= {cfg[L-2:0], bs_in}.
  - The first bit shifted in ends at cfg[L-1] (thresh MSB).
  - bs_out = cfg[L-1]: a bit presented on bs_in reappears L cycles later.
- During conf_en=1: U, refractory counter and axon hold their values, except axon is forced to 0. conf_en has priority over nn_clear.
- nn_clear=1 (with conf_en=0): U<=0, rcnt<=0, axon<=0.
- Run mode (conf_en=0, nn_clear=0), per rising edge:
  - If rcnt!=0: rcnt<=rcnt-1, U<=0, axon<=0. Inputs are ignored.
  - Else:
    - Leak: Ul = dbus[tsel] ? U>>1 : U.
    - Sum: s = Ul + sum over i of (dend[i] ? (inh[i] ? -mag[i] : +mag[i]) : 0), computed signed at U_W + clog2(N_DEND) + 2 bits.
    - Clamp: s<0 gives 0; s > 2**U_W-1 gives 2**U_W-1.
    - Fire: if thresh!=0 and clamped s >= thresh, then axon<=1, U<=0, rcnt<=refr.
    - Otherwise: axon<=0, U<=clamped s.
- thresh==0 disables firing; U still integrates and saturates.
- refr==0 means no refractory period; integration resumes on the next edge.
- Spike latency: one edge. axon is high during the cycle after the edge on which the threshold was crossed.
- Async reset (nn_reset_n=0), any time including mid-shift: cfg, U, rcnt, axon all 0, so bs_out=0 and u_mon=0. Release is synchronous to the next edge.
- u_mon = U, directly from the register.
- No combinational path from dend or dbus to axon or bs_out.

Decomposition:
- Shared package fpna_pkg holds:
  - Chain-length and field-offset localparam functions (L, D, per-field offsets) for use by the array builder and testbench.
  - Default parameter constants.
- One sub-module, neuron_cfg_chain: parametrised shift register with field slicing outputs (mag[], inh[], tsel, refr, thresh).
- Integrate/leak/fire logic stays in lif_neuron_cfg.

Test Plan (defaults, L=22):
- Chain integrity: reset, shift 22-bit pattern 0x2A5C3 + 22 zeros with conf_en=1 -> bs_out reproduces the pattern starting at cycle 22; fields decode per the layout.
- Integrate/fire/refractory: config w0=+5, thresh=16, refr=2, tsel=0, dbus=0; dend=3'b001 held.
  - Edges 1-3: U = 5, 10, 15.
  - Edge 4: axon=1, U=0.
  - Edges 5-6: U=0, axon=0.
  - Edge 7: U=5.
- Inhibition/floor: w1=inh mag 3, U preloaded to 10 via excitation, then dend=3'b010 -> U = 7, 4, 1, 0, 0; no spike.
- Leak: tsel=2, U=12, dend=0, dbus=8'h04 -> U = 6, 3, 1, 0; dbus=8'h00 -> U holds.
- Saturation/disable: thresh=0, all dendrites +7, dend=3'b111 -> U = 21, 31, 31; axon never asserts. Then thresh=31 -> fires on the first edge with clamped s=31.
- Reset/clear: nn_reset_n low mid-shift and mid-integration -> cfg, U, axon = 0 immediately, without waiting for clk. nn_clear=1 during run -> U=0, cfg unchanged, verified by shifting cfg out.
